// File: rtl/operand_fetch.sv
// Decode and operand-fetch stage feeding the ALU: splits the instruction word,
// reads rn/rm from a 16 x DATA_W register file and tracks in-flight writers.
module operand_fetch #(
    parameter int          DATA_W     = 32,
    parameter logic [3:0]  NOP_OPCODE = 4'b1111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              wb_en,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] in1,
    output logic [DATA_W-1:0] in2,
    output logic              s,
    output logic [3:0]        cond,
    output logic [3:0]        opcode,
    output logic [2:0]        srctrl,
    output logic [15:0]       imvalue,
    output logic [3:0]        rd,
    output logic              rd_we
);

    // Handshakes: a word moves on a rising edge where valid and ready are both
    // high. out_valid never depends on out_ready; in_ready may drop for flush,
    // reset or a hazard, and the upstream must then keep presenting its word.

    logic [DATA_W-1:0] r_rf [16];
    logic [15:0]       r_pending;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_in1;
    logic [DATA_W-1:0] r_in2;
    logic              r_s;
    logic [3:0]        r_cond;
    logic [3:0]        r_opcode;
    logic [2:0]        r_srctrl;
    logic [15:0]       r_imvalue;
    logic [3:0]        r_rd;
    logic              r_rd_we;

    logic [3:0]        w_cond;
    logic [3:0]        w_opcode;
    logic              w_s;
    logic [2:0]        w_srctrl;
    logic [3:0]        w_rd;
    logic [3:0]        w_rn;
    logic [3:0]        w_rm;
    logic [15:0]       w_imvalue;
    logic              w_rd_we;

    logic              w_byp_rn;
    logic              w_byp_rm;
    logic              w_byp_rd;
    logic              w_rn_pend;
    logic              w_rm_pend;
    logic              w_rd_pend;
    logic              w_held_hit;
    logic              w_hazard;
    logic              w_in_ready;
    logic              w_capture;
    logic              w_handoff;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic [15:0]       w_pending_nxt;

    assign w_cond    = instr[31:28];
    assign w_opcode  = instr[27:24];
    assign w_s       = instr[23];
    assign w_srctrl  = instr[22:20];
    assign w_rd      = instr[19:16];
    assign w_rn      = instr[15:12];
    assign w_rm      = instr[11:8];
    assign w_imvalue = instr[15:0];
    assign w_rd_we   = (w_opcode != NOP_OPCODE);

    // A register being written back this cycle is already resolved.
    assign w_byp_rn  = wb_en && (wb_addr == w_rn);
    assign w_byp_rm  = wb_en && (wb_addr == w_rm);
    assign w_byp_rd  = wb_en && (wb_addr == w_rd);
    assign w_rn_pend = r_pending[w_rn] && !w_byp_rn;
    assign w_rm_pend = r_pending[w_rm] && !w_byp_rm;
    assign w_rd_pend = r_pending[w_rd] && !w_byp_rd;

    // The held writer has not reached the scoreboard yet, so compare it directly.
    assign w_held_hit = r_out_valid && r_rd_we &&
                        ((r_rd == w_rn) || (r_rd == w_rm) || (w_rd_we && (r_rd == w_rd)));

    assign w_hazard   = w_rn_pend || w_rm_pend || (w_rd_we && w_rd_pend) || w_held_hit;
    assign w_in_ready = !rst && !flush && !w_hazard && (!r_out_valid || out_ready);
    assign w_capture  = in_valid && w_in_ready;
    assign w_handoff  = r_out_valid && out_ready && !flush;

    assign w_op1 = w_byp_rn ? wb_data : r_rf[w_rn];
    assign w_op2 = w_byp_rm ? wb_data : r_rf[w_rm];

    // Set is applied after clear so a same-index collision leaves the bit set.
    always_comb begin
        w_pending_nxt = r_pending;
        if (wb_en) begin
            w_pending_nxt[wb_addr] = 1'b0;
        end
        if (w_handoff && r_rd_we) begin
            w_pending_nxt[r_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wb_en) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_in1       <= '0;
            r_in2       <= '0;
            r_s         <= 1'b0;
            r_cond      <= '0;
            r_opcode    <= '0;
            r_srctrl    <= '0;
            r_imvalue   <= '0;
            r_rd        <= '0;
            r_rd_we     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_capture) begin
                r_out_valid <= 1'b1;
                r_in1       <= w_op1;
                r_in2       <= w_op2;
                r_s         <= w_s;
                r_cond      <= w_cond;
                r_opcode    <= w_opcode;
                r_srctrl    <= w_srctrl;
                r_imvalue   <= w_imvalue;
                r_rd        <= w_rd;
                r_rd_we     <= w_rd_we;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign in1       = r_in1;
    assign in2       = r_in2;
    assign s         = r_s;
    assign cond      = r_cond;
    assign opcode    = r_opcode;
    assign srctrl    = r_srctrl;
    assign imvalue   = r_imvalue;
    assign rd        = r_rd;
    assign rd_we     = r_rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and randomized checks of operand_fetch against a slot/array model
// of the register file, pending scoreboard and output slot.
module tb_operand_fetch;

    localparam logic [3:0] NOP = 4'b1111;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        s;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic [2:0]  srctrl;
    logic [15:0] imvalue;
    logic [3:0]  rd;
    logic        rd_we;

    operand_fetch #(.DATA_W(32), .NOP_OPCODE(NOP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .in1(in1), .in2(in2), .s(s), .cond(cond), .opcode(opcode),
        .srctrl(srctrl), .imvalue(imvalue), .rd(rd), .rd_we(rd_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] in1;
        logic [31:0] in2;
        logic        s;
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic [2:0]  srctrl;
        logic [15:0] imm;
        logic [3:0]  rd;
        logic        rd_we;
    } slot_t;

    logic [31:0] m_rf [16];
    bit          m_pend [16];
    slot_t       m_out;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] d,
                                       input logic [3:0] n, input logic [3:0] m,
                                       input logic sb);
        return {4'hE, op, sb, 3'b010, d, n, m, 8'h5A};
    endfunction

    function automatic bit still_pending(input logic [3:0] r);
        return m_pend[r] && !(wb_en && wb_addr == r);
    endfunction

    // Readiness derived from the hazard rules stated for the stage.
    function automatic bit model_ready();
        logic [3:0] rn_i, rm_i, rd_i;
        bit         we_i;
        rn_i = instr[15:12];
        rm_i = instr[11:8];
        rd_i = instr[19:16];
        we_i = (instr[27:24] != NOP);
        if (rst || flush) return 1'b0;
        if (m_out.valid && !out_ready) return 1'b0;
        if (still_pending(rn_i) || still_pending(rm_i)) return 1'b0;
        if (we_i && still_pending(rd_i)) return 1'b0;
        if (m_out.valid && m_out.rd_we &&
            (m_out.rd == rn_i || m_out.rd == rm_i || (we_i && m_out.rd == rd_i))) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit er);
        slot_t nxt;
        bit    handoff;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_rf[i]   = '0;
                m_pend[i] = 1'b0;
            end
            m_out = '0;
            return;
        end
        handoff      = m_out.valid && out_ready && !flush;
        nxt.valid    = 1'b1;
        nxt.in1      = (wb_en && wb_addr == instr[15:12]) ? wb_data : m_rf[instr[15:12]];
        nxt.in2      = (wb_en && wb_addr == instr[11:8])  ? wb_data : m_rf[instr[11:8]];
        nxt.s        = instr[23];
        nxt.cond     = instr[31:28];
        nxt.opcode   = instr[27:24];
        nxt.srctrl   = instr[22:20];
        nxt.imm      = instr[15:0];
        nxt.rd       = instr[19:16];
        nxt.rd_we    = (instr[27:24] != NOP);
        if (wb_en) m_pend[wb_addr] = 1'b0;
        if (handoff && m_out.rd_we) m_pend[m_out.rd] = 1'b1;
        if (wb_en) m_rf[wb_addr] = wb_data;
        if (flush) m_out.valid = 1'b0;
        else if (in_valid && er) m_out = nxt;
        else if (out_ready) m_out.valid = 1'b0;
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_out.valid});
        chk("in1", in1, m_out.in1);
        chk("in2", in2, m_out.in2);
        chk("s", {31'd0, s}, {31'd0, m_out.s});
        chk("cond", {28'd0, cond}, {28'd0, m_out.cond});
        chk("opcode", {28'd0, opcode}, {28'd0, m_out.opcode});
        chk("srctrl", {29'd0, srctrl}, {29'd0, m_out.srctrl});
        chk("imvalue", {16'd0, imvalue}, {16'd0, m_out.imm});
        chk("rd", {28'd0, rd}, {28'd0, m_out.rd});
        chk("rd_we", {31'd0, rd_we}, {31'd0, m_out.rd_we});
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        bit er;
        #1;
        er = model_ready();
        chk("in_ready", {31'd0, in_ready}, {31'd0, er});
        @(posedge clk);
        model_edge(er);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic set_wb(input bit en, input logic [3:0] a, input logic [31:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        logic [3:0] cand [$];
        logic [3:0] op_r;

        rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b0;
        set_wb(1'b0, 4'd0, 32'd0);
        m_out = '0;
        for (int i = 0; i < 16; i++) begin
            m_rf[i] = '0;
            m_pend[i] = 1'b0;
        end
        @(negedge clk);
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;

        // Reset then load
        set_wb(1'b1, 4'd1, 32'd5);  tick();
        set_wb(1'b1, 4'd2, 32'd11); tick();
        set_wb(1'b0, 4'd0, 32'd0);
        instr = mk(4'd1, 4'd3, 4'd1, 4'd2, 1'b1); in_valid = 1'b1;
        tick();
        chk("load_out_valid", {31'd0, out_valid}, 32'd1);
        chk("load_in1", in1, 32'd5);
        chk("load_in2", in2, 32'd11);
        chk("load_rd_we", {31'd0, rd_we}, 32'd1);
        chk("load_opcode", {28'd0, opcode}, 32'd1);

        // Backpressure for three cycles, then handoff + capture together
        instr = mk(4'd2, 4'd5, 4'd1, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_in1_hold", in1, 32'd5);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_new_opcode", {28'd0, opcode}, 32'd2);
        in_valid = 1'b0;
        tick();

        // RAW on R3 until writeback, captured through the bypass
        instr = mk(4'd3, 4'd7, 4'd3, 4'd1, 1'b0); in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("raw_stall", {31'd0, in_ready}, 32'd0);
        end
        set_wb(1'b1, 4'd3, 32'd16);
        #1 chk("raw_wb_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("raw_bypass_in1", in1, 32'd16);
        in_valid = 1'b0;
        set_wb(1'b1, 4'd5, 32'd55); tick();
        set_wb(1'b1, 4'd7, 32'd77); tick();
        set_wb(1'b0, 4'd0, 32'd0);

        // NOP does not mark its rd pending
        instr = mk(NOP, 4'd4, 4'd1, 4'd2, 1'b0); in_valid = 1'b1;
        tick();
        chk("nop_rd_we", {31'd0, rd_we}, 32'd0);
        instr = mk(4'd1, 4'd8, 4'd4, 4'd2, 1'b0);
        #1 chk("nop_reader_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; tick();
        set_wb(1'b1, 4'd8, 32'd88); tick();
        set_wb(1'b0, 4'd0, 32'd0);

        // Flush of a held writer, coincident with out_ready
        out_ready = 1'b0;
        instr = mk(4'd2, 4'd6, 4'd1, 4'd1, 1'b0); in_valid = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        tick();
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        instr = mk(4'd1, 4'd9, 4'd6, 4'd6, 1'b0); in_valid = 1'b1;
        #1 chk("flush_reader_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Reset while a reader of R3 is stalled
        instr = mk(4'd2, 4'd3, 4'd1, 4'd2, 1'b0);
        tick();
        instr = mk(4'd1, 4'd10, 4'd3, 4'd3, 1'b0);
        tick();
        tick();
        chk("mid_stall_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("post_rst_r3", in1, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            op_r      = ($urandom_range(0, 7) == 0) ? NOP : 4'($urandom_range(0, 14));
            instr     = {4'($urandom_range(0, 15)), op_r, 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                         4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                         8'($urandom_range(0, 255))};
            if ($urandom_range(0, 2) == 0) begin
                cand.delete();
                for (int i = 0; i < 16; i++) if (m_pend[i]) cand.push_back(4'(i));
                if (cand.size() > 0)
                    set_wb(1'b1, cand[$urandom_range(0, cand.size() - 1)], $urandom);
                else
                    set_wb(1'b1, 4'($urandom_range(0, 15)), $urandom);
            end else begin
                set_wb(1'b0, 4'd0, 32'd0);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
